// File: rtl/fetch_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_hs
// Purpose  : Instruction-fetch stage plus IF/ID pipeline register for the
//            5-stage RISC-V core. Keeps the PC and issues one instruction
//            memory read at a time over a req/gnt/rvalid handshake. It also
//            presents fetched instructions with their PC to decode. Handles
//            decode back-pressure and branch/jump redirection, including
//            discarding responses that arrive after a redirect.
// Ports    : clk_i, rst_ni          clock (rising edge), async active-low reset
//            imem_req_o/addr_o     read request / address (= PC register)
//            imem_gnt_i            memory accepted the request
//            imem_rvalid_i/rdata_i read response
//            id_stall_i            decode cannot accept, hold IF/ID
//            redirect_valid_i/pc_i load new PC, kill younger work
//            if_id_valid_o/pc_o/instr_o  IF/ID pipeline register
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage_hs #(
    parameter int                XLEN      = 32,
    parameter int                ILEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter int                PC_STEP   = 4,
    parameter logic [ILEN-1:0]   NOP_INSTR = ILEN'(32'h0000_0013)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            id_stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [ILEN-1:0] if_id_instr_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request driven, waiting for grant
        S_WAIT = 2'd1,  // request accepted, waiting for response
        S_HOLD = 2'd2,  // response buffered while decode is stalled
        S_DROP = 2'd3   // stale response still due, discard it
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [ILEN-1:0] hold_instr_q, hold_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;

    logic            dlv;
    logic [XLEN-1:0] dlv_pc;
    logic [ILEN-1:0] dlv_instr;
    logic [XLEN-1:0] pc_next_seq;

    assign pc_next_seq = pc_q + XLEN'(PC_STEP);

    // Request is a pure state decode; gating with the reset pin keeps the
    // request low for the whole time reset is asserted.
    assign imem_req_o    = rst_ni && (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = if_id_valid_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        dlv          = 1'b0;
        dlv_pc       = pc_q;
        dlv_instr    = imem_rdata_i;

        case (state_q)
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (!id_stall_i) begin
                        dlv     = 1'b1;
                        pc_d    = pc_next_seq;
                        state_d = S_REQ;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata_i;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall_i) begin
                    dlv       = 1'b1;
                    dlv_pc    = hold_pc_q;
                    dlv_instr = hold_instr_q;
                    pc_d      = pc_next_seq;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over everything. A request that is granted or still
        // outstanding will produce a response we must swallow in DROP.
        if (redirect_valid_i) begin
            dlv  = 1'b0;
            pc_d = redirect_pc_i;
            case (state_q)
                S_REQ:   state_d = imem_gnt_i    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid_i ? S_REQ  : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rvalid_i ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if (redirect_valid_i) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (id_stall_i) begin
            // hold every field
        end else if (dlv) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = dlv_pc;
            if_id_instr_d = dlv_instr;
        end else begin
            // bubble: PC is left as-is, only valid/instr are scrubbed
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            hold_pc_q     <= '0;
            hold_instr_q  <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage_hs
// Purpose  : Self-checking bench for fetch_stage_hs. A small memory model
//            answers requests (rdata = addr ^ 32'hA5A5_0000). Each accepted,
//            non-stale response is queued as an expected IF/ID entry and
//            popped when decode sees a new valid instruction. A cycle table
//            covers the basic fetch/stall sequence. Hand sequences cover
//            redirect, grant back-pressure and mid-transaction reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage_hs;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall, redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;
    logic        req2, valid2;
    logic [31:0] addr2, pc2, instr2;

    always #5 clk = ~clk;

    fetch_stage_hs dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .id_stall_i(id_stall), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .if_id_valid_o(if_id_valid), .if_id_pc_o(if_id_pc), .if_id_instr_o(if_id_instr)
    );

    // Runs in lockstep with dut; its PC is always 4 below, exercising wrap.
    fetch_stage_hs #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .id_stall_i(id_stall), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .if_id_valid_o(valid2), .if_id_pc_o(pc2), .if_id_instr_o(instr2)
    );

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    int    errors = 0;
    int    checks = 0;
    item_t q[$];

    // memory model state
    bit          gnt_en = 1'b1;
    int          lat = 1;
    bit          pending = 1'b0;
    bit          stale = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] addr_s = 32'h0;
    bit          pstall = 1'b0;
    bit          predir = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        // A valid IF/ID that was merely held by a stall is not a new entry.
        if (if_id_valid && !(pstall && !predir)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no delivery at %0t", if_id_pc, $time);
            end else begin
                item_t e;
                e = q.pop_front();
                chk("sb_pc", if_id_pc, e.pc);
                chk("sb_instr", if_id_instr, e.instr);
            end
        end
        if (!if_id_valid) chk("bubble_instr", if_id_instr, NOP);
    endtask

    // Called at a negedge: drive memory inputs, model the clock edge,
    // then compare at the following negedge.
    task automatic step();
        imem_gnt    = gnt_en && imem_req;
        addr_s      = imem_addr;
        imem_rvalid = pending && (cnt == 0);
        imem_rdata  = imem_rvalid ? (paddr ^ MASK) : 32'hDEAD_BEEF;
        @(posedge clk);
        pstall = id_stall;
        predir = redirect_valid;
        if (redirect_valid) q.delete();
        if (imem_rvalid) begin
            if (!stale && !redirect_valid) q.push_back('{paddr, paddr ^ MASK});
            pending = 1'b0;
        end else if (pending) begin
            cnt--;
            if (redirect_valid) stale = 1'b1;
        end
        if (imem_gnt) begin
            pending = 1'b1;
            stale   = redirect_valid;
            paddr   = addr_s;
            cnt     = lat - 1;
        end
        @(negedge clk);
        sb_check();
    endtask

    task automatic run_until_valid(input int maxc, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (if_id_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no delivery expected one within %0d cycles", name, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'd4,  1'b0, 32'd0};
        tbl[4]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[5]  = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd4};
        tbl[6]  = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd4};
        tbl[7]  = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd4};
        tbl[8]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[9]  = '{1'b0, 1'b0, 32'd12, 1'b0, 32'd8};
        tbl[10] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12};

        rst_n = 1'b0;
        id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_addr_wrap", addr2, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 11; i++) begin
            chk("tbl_req", {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
            chk("tbl_addr", imem_addr, tbl[i].exp_addr);
            chk("tbl_valid", {31'd0, if_id_valid}, {31'd0, tbl[i].exp_valid});
            chk("tbl_pc", if_id_pc, tbl[i].exp_pc);
            chk("tbl_instr", if_id_instr, tbl[i].exp_valid ? (tbl[i].exp_pc ^ MASK) : NOP);
            chk("tbl_addr_wrap", addr2, tbl[i].exp_addr + 32'hFFFF_FFFC);
            id_stall = tbl[i].stall;
            if (i == 10) lat = 3;
            step();
        end

        // Redirect while waiting; the stale response arrives two cycles later.
        id_stall = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("drop2_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        lat = 1;
        step();
        chk("redir_wait_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("redir_first_valid", {31'd0, if_id_valid}, 32'd1);
        chk("redir_first_pc", if_id_pc, 32'h100);

        // Grant withheld for four cycles.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("nogrant_req", {31'd0, imem_req}, 32'd1);
            chk("nogrant_addr", imem_addr, 32'h104);
            step();
        end
        gnt_en = 1'b1;
        chk("grant_addr", imem_addr, 32'h104);
        step();
        step();
        chk("grant_pc", if_id_pc, 32'h104);

        // Redirect together with stall while a response is buffered.
        id_stall = 1'b1;
        step();
        step();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc", if_id_pc, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0; id_stall = 1'b0;
        chk("hold_redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
        chk("hold_redir_addr", imem_addr, 32'h200);
        run_until_valid(10, "hold_redir_deliver");
        chk("hold_redir_pc", if_id_pc, 32'h200);

        // Reset asserted while a request is outstanding.
        step();
        chk("prerst_req", {31'd0, imem_req}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_pc", if_id_pc, 32'd0);
        chk("arst_instr", if_id_instr, NOP);
        q.delete();
        stale = 1'b1; pending = 1'b1; cnt = 0;
        pstall = 1'b0; predir = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);
        gnt_en = 1'b0;
        step();
        chk("late_rsp_req", {31'd0, imem_req}, 32'd1);
        chk("late_rsp_valid", {31'd0, if_id_valid}, 32'd0);
        gnt_en = 1'b1;
        run_until_valid(10, "post_rst_deliver");
        chk("post_rst_pc", if_id_pc, 32'd0);
        chk("sb_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage_hs.md
# fetch_stage_hs

Parametrised instruction-fetch stage and IF/ID pipeline register for the 5-stage RISC-V core. Holds the program counter, issues one instruction-memory read at a time over a request/grant/response handshake, and presents fetched instructions with their PC to decode. Supports decode back-pressure (stall) and branch/jump redirection with discard of in-flight stale responses.

## Interface
- XLEN, 32, PC and address width in bits
- ILEN, 32, instruction width in bits
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, sequential PC increment
- NOP_INSTR, 32'h00000013, value of if_id_instr under reset or bubble

- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  read request valid
- imem_addr  out  XLEN  read address, equals PC register
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  ILEN  read data
- id_stall  in  1  decode cannot accept; hold IF/ID
- redirect_valid  in  1  load redirect_pc, kill younger work
- redirect_pc  in  XLEN  redirect target
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  XLEN  PC of IF/ID instruction
- if_id_instr  out  ILEN  IF/ID instruction

## Operation
- Reset (reset=0, asynchronous): pc=RESET_PC, state=REQ, drop=0, hold buffer empty, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR. imem_req=0 while reset asserted.
- States: REQ (imem_req=1), WAIT (request accepted, awaiting response), HOLD (response buffered, decode stalled), DROP (awaiting stale response to discard).
- REQ: imem_gnt=1 -> WAIT; else stay REQ, imem_addr stable.
- WAIT, imem_rvalid=1, id_stall=0: IF/ID <= {1, pc, imem_rdata}; pc <= pc+PC_STEP; -> REQ.
- WAIT, imem_rvalid=1, id_stall=1: capture {pc, imem_rdata} into hold buffer; -> HOLD. IF/ID unchanged.
- HOLD, id_stall=0: IF/ID <= hold buffer, valid=1; pc <= pc+PC_STEP; -> REQ.
- DROP, imem_rvalid=1: discard data; -> REQ. No IF/ID update.
- Exactly one outstanding request; imem_rvalid outside WAIT/DROP is ignored.
- IF/ID update when not stalled and no instruction delivered this cycle: if_id_valid <= 0 (bubble), if_id_instr <= NOP_INSTR, if_id_pc held.
- id_stall=1: IF/ID registers hold all fields.
- redirect_valid=1 (highest priority, overrides id_stall): pc <= redirect_pc; if_id_valid <= 0, if_id_instr <= NOP_INSTR; hold buffer discarded. Next state: from REQ with imem_gnt=1 -> DROP; from REQ without grant -> REQ; from WAIT with imem_rvalid=0 -> DROP; from WAIT with imem_rvalid=1 -> REQ (data discarded); from HOLD -> REQ; from DROP with imem_rvalid=0 -> DROP, with imem_rvalid=1 -> REQ.
- Arithmetic: pc+PC_STEP truncated to XLEN, wraps modulo 2^XLEN. No alignment checking; redirect_pc used verbatim.

## Timing
- imem_req, imem_addr are registered-state decodes (no combinational path from memory inputs).
- Minimum fetch interval: 2 cycles per instruction with zero-wait grant and 1-cycle response (REQ, WAIT).
- Fetch-to-IF/ID latency: instruction visible on if_id_* the cycle after imem_rvalid (or after id_stall falls, from HOLD).
- Redirect: imem_addr=redirect_pc on the cycle after redirect_valid if no stale response pending; first redirected instruction in IF/ID no earlier than 3 cycles after redirect_valid.
- First request after reset release: imem_req=1, imem_addr=RESET_PC in the first cycle reset=1.
- Reset mid-transaction: all state cleared immediately; a response arriving after reset release is ignored (state REQ).

## Test plan
- Reset then 1-cycle memory, always granting, rdata=addr^32'hA5A5_0000: if_id_pc sequence 0,4,8,... every 2 cycles, if_id_valid pulses 1,0,1,...; outputs 0/NOP while reset=0.
- id_stall held 3 cycles across a response at pc=8: instruction buffered (HOLD), IF/ID holds pc=4 entry; on release pc=8 appears next cycle, no loss or duplication.
- redirect_valid with redirect_pc=0x100 while in WAIT, response arrives 2 cycles later: response discarded, imem_addr=0x100 next request, if_id_valid=0 until 0x100 delivered.
- redirect_valid and id_stall asserted together in HOLD: hold buffer dropped, if_id_valid=0, next request at target.
- RESET_PC=32'hFFFF_FFFC, PC_STEP=4: second fetch address wraps to 0x0000_0000.
- imem_gnt low 4 cycles in REQ: imem_req stays 1, imem_addr stable; reset asserted mid-WAIT returns pc to RESET_PC, IF/ID to 0/NOP asynchronously.
